// File: rtl/req_arbiter.sv
`default_nettype none
// ============================================================================
// req_arbiter : 8-way request arbiter (fixed priority or round-robin)
//               with done/withdraw/timeout release and a one-cycle gap
// Revision    : 1.0
// ============================================================================
module req_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_n,
    input  logic       rr_en,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] last_id;

    logic [7:0] req;
    logic       any_req;
    logic [2:0] start;
    logic [2:0] idx;
    logic [2:0] win_id;
    logic       found;
    logic       withdraw;
    logic       expire;
    logic       release_now;

    assign req      = ~req_n;
    assign any_req  = |req;
    assign withdraw = req_n[gnt_id];
    assign expire   = (cnt == CNT_LAST);
    assign release_now = done | withdraw | expire;

    // Descending search from the start index with 3-bit wrap; fixed mode starts at 7.
    always_comb begin
        start  = rr_en ? (last_id - 3'd1) : 3'd7;
        win_id = 3'd0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = start - 3'(i);
            if (!found && req[idx]) begin
                win_id = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= 8'd0;
            last_id   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (any_req) begin
                        state     <= GRANT;
                        gnt       <= 8'd1 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        cnt       <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= GAP;
                        gnt       <= 8'h00;
                        gnt_id    <= 3'd0;
                        gnt_valid <= 1'b0;
                        last_id   <= gnt_id;
                        cnt       <= 8'd0;
                        // Only a pure counter expiry is reported as a timeout.
                        timeout   <= expire & ~done & ~withdraw;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    timeout <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 8'h00;
                    gnt_id    <= 3'd0;
                    gnt_valid <= 1'b0;
                    timeout   <= 1'b0;
                    cnt       <= 8'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_req_arbiter : directed self-checking bench for req_arbiter
// Revision       : 1.0
// ============================================================================
module tb_req_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_n = 8'hFF;
    logic       rr_en = 1'b0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    logic [12:0] obs;
    int total = 0;
    int bad   = 0;

    // {gnt, gnt_id, gnt_valid, timeout}
    localparam logic [12:0] NONE  = 13'h0000;
    localparam logic [12:0] TOUT  = {8'h00, 3'd0, 1'b0, 1'b1};

    assign obs = {gnt, gnt_id, gnt_valid, timeout};

    req_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_n     (req_n),
        .rr_en     (rr_en),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", obs, NONE);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL reset_idle: got %h want %h", obs, NONE);
        end
    endtask

    task automatic test_fixed();
        logic [12:0] exp6;
        exp6 = {8'h40, 3'd6, 1'b1, 1'b0};
        rr_en = 1'b0;
        req_n = 8'b1010_1111;
        tick();
        total++;
        if (obs !== exp6) begin
            bad++;
            $display("FAIL fixed_first: got %h want %h", obs, exp6);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL fixed_gap: got %h want %h", obs, NONE);
        end
        tick();
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL fixed_idle: got %h want %h", obs, NONE);
        end
        tick();
        total++;
        if (obs !== exp6) begin
            bad++;
            $display("FAIL fixed_regrant: got %h want %h", obs, exp6);
        end
        req_n = 8'hFF;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [12:0] exp;
        int k;
        do_reset();
        rr_en = 1'b1;
        req_n = 8'h00;
        done  = 1'b1;
        for (int n = 0; n < 9; n++) begin
            k = (15 - n) % 8;
            exp = {8'(1 << k), 3'(k), 1'b1, 1'b0};
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rr_grant%0d: got %h want %h", n, obs, exp);
            end
            if (n < 8) begin
                tick();
                total++;
                if (obs !== NONE) begin
                    bad++;
                    $display("FAIL rr_gap%0d: got %h want %h", n, obs, NONE);
                end
                tick();
                total++;
                if (obs !== NONE) begin
                    bad++;
                    $display("FAIL rr_idle%0d: got %h want %h", n, obs, NONE);
                end
            end
        end
        req_n = 8'hFF;
        tick();
        done  = 1'b0;
        rr_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [12:0] exp0;
        exp0 = {8'h01, 3'd0, 1'b1, 1'b0};
        do_reset();
        rr_en = 1'b0;
        req_n = 8'b1111_1110;
        for (int c = 0; c < 16; c++) begin
            tick();
            total++;
            if (obs !== exp0) begin
                bad++;
                $display("FAIL tout_hold%0d: got %h want %h", c, obs, exp0);
            end
        end
        tick();
        total++;
        if (obs !== TOUT) begin
            bad++;
            $display("FAIL tout_pulse: got %h want %h", obs, TOUT);
        end
        tick();
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL tout_pulse_end: got %h want %h", obs, NONE);
        end
        // Regrant, then collide done with the expiry edge.
        for (int c = 0; c < 16; c++) begin
            tick();
            total++;
            if (obs !== exp0) begin
                bad++;
                $display("FAIL collide_hold%0d: got %h want %h", c, obs, exp0);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req_n = 8'hFF;
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL collide_no_tout: got %h want %h", obs, NONE);
        end
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        logic [12:0] exp2;
        logic [12:0] exp7;
        exp2 = {8'h04, 3'd2, 1'b1, 1'b0};
        exp7 = {8'h80, 3'd7, 1'b1, 1'b0};
        rr_en = 1'b0;
        req_n = 8'b1111_1011;
        tick();
        total++;
        if (obs !== exp2) begin
            bad++;
            $display("FAIL wd_grant2: got %h want %h", obs, exp2);
        end
        req_n = 8'b0111_1011;
        // rr_en flip mid-grant must not matter until the next arbitration.
        rr_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (obs !== exp2) begin
                bad++;
                $display("FAIL wd_no_preempt%0d: got %h want %h", c, obs, exp2);
            end
        end
        rr_en = 1'b0;
        req_n = 8'b0111_1111;
        tick();
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL wd_release: got %h want %h", obs, NONE);
        end
        tick();
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL wd_idle: got %h want %h", obs, NONE);
        end
        tick();
        total++;
        if (obs !== exp7) begin
            bad++;
            $display("FAIL wd_grant7: got %h want %h", obs, exp7);
        end
        req_n = 8'hFF;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        logic [12:0] exp3;
        logic [12:0] exp7;
        exp3 = {8'h08, 3'd3, 1'b1, 1'b0};
        exp7 = {8'h80, 3'd7, 1'b1, 1'b0};
        rr_en = 1'b0;
        req_n = 8'b1111_0111;
        tick();
        total++;
        if (obs !== exp3) begin
            bad++;
            $display("FAIL ar_grant3: got %h want %h", obs, exp3);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== NONE) begin
            bad++;
            $display("FAIL ar_drop: got %h want %h", obs, NONE);
        end
        #1;
        rst   = 1'b0;
        rr_en = 1'b1;
        req_n = 8'h00;
        tick();
        total++;
        if (obs !== exp7) begin
            bad++;
            $display("FAIL ar_first7: got %h want %h", obs, exp7);
        end
        req_n = 8'hFF;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
